// File: rtl/matriz_pkg.sv
// Shared types and default geometry for the LED matrix scanner.
package matriz_pkg;
  localparam int DEF_ROWS     = 7;
  localparam int DEF_COLS     = 5;
  localparam int DEF_SCAN_DIV = 1000;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;
endpackage

// File: rtl/matriz_prescaler.sv
// Column-period prescaler: counts 0..SCAN_DIV-1 while enabled and strobes tc on the last count.
module matriz_prescaler
  import matriz_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  output logic [$clog2(SCAN_DIV)-1:0] cnt,
  output logic                        tc
);
  localparam int              PW   = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]   LAST = PW'(SCAN_DIV - 1);

  assign tc = en && (cnt == LAST);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + PW'(1);
    end
  end
endmodule

// File: rtl/matriz_scan.sv
// Column-multiplexed LED matrix scanner with a double-buffered frame store.
// Writes go to the back buffer; front/back exchange only at a frame wrap.
module matriz_scan
  import matriz_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [$clog2(COLS)-1:0] wr_col,
  input  logic                    wr_pix,
  input  logic                    clr_req,
  input  logic                    swap_req,
  output logic [ROWS-1:0]         row_n,
  output logic [COLS-1:0]         col_en,
  output logic                    frame_done,
  output logic                    wr_err
);
  localparam int            RW       = $clog2(ROWS);
  localparam int            CW       = $clog2(COLS);
  localparam int            PW       = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW:0]   ROWS_W   = (RW+1)'(ROWS);
  localparam logic [CW:0]   COLS_W   = (CW+1)'(COLS);

  logic                           alive_q;  // high from the first edge after reset release
  logic [PW-1:0]                  cnt;
  logic                           tc;
  logic [CW-1:0]                  col_idx_q;
  logic                           frame_wrap, wrap_q;
  logic                           front_q, back_sel, pending_q, swap_now;
  clr_state_t                     state_q, state_d;
  logic [CW-1:0]                  clr_idx_q, clr_idx_d;
  logic                           clr_col;
  logic                           wr_acc, in_range;
  logic [1:0][COLS-1:0][ROWS-1:0] fb_q;

  matriz_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (alive_q),
    .cnt  (cnt),
    .tc   (tc)
  );

  assign back_sel   = ~front_q;
  assign frame_wrap = tc && (col_idx_q == COL_LAST);
  assign swap_now   = frame_wrap && pending_q && (state_q == IDLE);
  assign wr_ready   = alive_q && (state_q == IDLE) && !clr_req;
  assign wr_acc     = wr_valid && wr_ready;
  assign in_range   = ({1'b0, wr_row} < ROWS_W) && ({1'b0, wr_col} < COLS_W);

  // Clear sequencer: one back-buffer column per cycle; a clear request beats a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_col   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        clr_col = 1'b1;
        if (clr_idx_q == COL_LAST) begin
          state_d = IDLE;
        end else begin
          clr_idx_d = clr_idx_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q   <= 1'b0;
      col_idx_q <= '0;
      wrap_q    <= 1'b0;
      front_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      wrap_q  <= frame_wrap;
      if (tc) begin
        col_idx_q <= (col_idx_q == COL_LAST) ? '0 : col_idx_q + CW'(1);
      end
      front_q   <= front_q ^ swap_now;
      pending_q <= swap_now ? 1'b0 : (pending_q | swap_req);
    end
  end

  // NOTE: the frame store is reset explicitly because a reset must leave a blank display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_q <= '0;
    end else begin
      if (clr_col) begin
        fb_q[back_sel][clr_idx_q] <= '0;
      end
      if (wr_acc && in_range) begin
        fb_q[back_sel][wr_col][wr_row] <= wr_pix;
      end
    end
  end

  // Registered drive outputs; the first count of each column period is blanked against ghosting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_n      <= '1;
      col_en     <= '0;
      frame_done <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      col_en     <= alive_q ? (COLS'(1) << col_idx_q) : '0;
      row_n      <= (!alive_q || (cnt == '0)) ? '1 : ~fb_q[front_q][col_idx_q];
      frame_done <= wrap_q;
      wr_err     <= wr_acc && !in_range;
    end
  end
endmodule
